// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: command opcodes and FSM state encoding.
package stack_pkg;

   // Command opcodes carried on cmd_op
   typedef enum logic [1:0] {
      OP_PUSH  = 2'b00,
      OP_POP   = 2'b01,
      OP_PEEK  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   // Command/response handshake state
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

endpackage : stack_pkg

// File: rtl/stack_mem.sv
// Single-port WIDTH x DEPTH register array for the stack storage.
// Ports:
//   clk      - clock; writes occur on its rising edge
//   we_i     - write enable
//   addr_i   - shared read/write address
//   wdata_i  - write data
//   rdata_o  - asynchronous read data at addr_i
// Contents are intentionally not reset.
module stack_mem #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Synchronous write
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Asynchronous read
   assign rdata_o = mem_q[addr_i];

endmodule : stack_mem

// File: rtl/lifo_stack.sv
// LIFO stack with a command/response handshake.
// One command is accepted in IDLE, its result is held in RESP until the
// consumer takes it, so back-to-back throughput is one command per two cycles.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_op, cmd_data - command channel (PUSH/POP/PEEK/CLEAR)
//   rsp_valid/rsp_ready, rsp_data, rsp_err - response channel
//   empty, full, count - occupancy, decoded from the stack pointer
//   ovf_sticky, unf_sticky, err_clr - sticky overflow/underflow flags and clear
module lifo_stack
   import stack_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             cmd_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             ovf_sticky,
   output logic             unf_sticky,
   input  logic             err_clr
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    sp_q, sp_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic             ovf_q, unf_q;
   logic             ovf_set, unf_set;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_rdata;
   logic             is_empty, is_full;

   assign is_empty = (sp_q == '0);
   assign is_full  = (sp_q == CW'(DEPTH));

   // Storage; writes are suppressed in a reset cycle so a command there has no effect
   stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we & ~rst),
      .addr_i  (mem_addr),
      .wdata_i (cmd_data),
      .rdata_o (mem_rdata)
   );

   // Next-state, pointer and response computation
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      mem_we     = 1'b0;
      mem_addr   = AW'(sp_q);
      ovf_set    = 1'b0;
      unf_set    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d    = ST_RESP;
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               case (op_e'(cmd_op))
                  OP_PUSH: begin
                     if (is_full) begin
                        rsp_err_d = 1'b1;
                        ovf_set   = 1'b1;
                     end else begin
                        mem_we = 1'b1;
                        sp_d   = sp_q + CW'(1);
                     end
                  end
                  OP_POP, OP_PEEK: begin
                     // Top of stack lives one below the pointer
                     mem_addr = AW'(sp_q - CW'(1));
                     if (is_empty) begin
                        rsp_err_d = 1'b1;
                        unf_set   = 1'b1;
                     end else begin
                        rsp_data_d = mem_rdata;
                        if (op_e'(cmd_op) == OP_POP) begin
                           sp_d = sp_q - CW'(1);
                        end
                     end
                  end
                  OP_CLEAR: begin
                     sp_d = '0;
                  end
                  default: ;
               endcase
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; a new error event wins over a coincident err_clr
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sp_q       <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         ovf_q      <= ovf_set | (ovf_q & ~err_clr);
         unf_q      <= unf_set | (unf_q & ~err_clr);
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign empty      = is_empty;
   assign full       = is_full;
   assign count      = sp_q;
   assign ovf_sticky = ovf_q;
   assign unf_sticky = unf_q;

endmodule : lifo_stack

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack (WIDTH=8, DEPTH=4): table of commands with
// hand-computed responses, plus sequences for back-pressure, set-wins and reset abort.
module tb_lifo_stack;
   import stack_pkg::*;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       empty;
   logic       full;
   logic [2:0] count;
   logic       ovf_sticky;
   logic       unf_sticky;
   logic       err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0] op;
      logic [7:0] data;
      logic       clr;      // pulse err_clr in a cycle before the command
      logic [7:0] exp_data;
      logic       exp_err;
      logic [2:0] exp_cnt;
      logic       exp_ovf;
      logic       exp_unf;
   } vec_t;

   vec_t vecs [18];

   lifo_stack #(
      .WIDTH (8),
      .DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .cmd_ready  (cmd_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .ovf_sticky (ovf_sticky),
      .unf_sticky (unf_sticky),
      .err_clr    (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one command from IDLE; returns at the following negedge (in RESP)
   task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic clr);
      int n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready before issue", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      err_clr   = clr;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      err_clr   = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 8'h00;
      rsp_ready = 1'b1;
      err_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      check("reset cmd_ready",  32'(cmd_ready),  32'd1);
      check("reset rsp_valid",  32'(rsp_valid),  32'd0);
      check("reset empty",      32'(empty),      32'd1);
      check("reset full",       32'(full),       32'd0);
      check("reset count",      32'(count),      32'd0);
      check("reset ovf_sticky", 32'(ovf_sticky), 32'd0);
      check("reset unf_sticky", 32'(unf_sticky), 32'd0);

      //          op        data   clr   exp_d  err   cnt   ovf   unf
      vecs[0]  = '{OP_PUSH,  8'h11, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[1]  = '{OP_PUSH,  8'h22, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0};
      vecs[2]  = '{OP_PUSH,  8'h33, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0};
      vecs[3]  = '{OP_POP,   8'h00, 1'b0, 8'h33, 1'b0, 3'd2, 1'b0, 1'b0};
      vecs[4]  = '{OP_POP,   8'h00, 1'b0, 8'h22, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[5]  = '{OP_POP,   8'h00, 1'b0, 8'h11, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[6]  = '{OP_PUSH,  8'h01, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[7]  = '{OP_PUSH,  8'h02, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0};
      vecs[8]  = '{OP_PUSH,  8'h03, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0};
      vecs[9]  = '{OP_PUSH,  8'h04, 1'b0, 8'h00, 1'b0, 3'd4, 1'b0, 1'b0};
      vecs[10] = '{OP_PUSH,  8'h55, 1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0};
      vecs[11] = '{OP_POP,   8'h00, 1'b0, 8'h04, 1'b0, 3'd3, 1'b1, 1'b0};
      vecs[12] = '{OP_CLEAR, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[13] = '{OP_POP,   8'h00, 1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1};
      vecs[14] = '{OP_PUSH,  8'hA5, 1'b1, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[15] = '{OP_PEEK,  8'h00, 1'b0, 8'hA5, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[16] = '{OP_CLEAR, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[17] = '{OP_PEEK,  8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1};

      for (int i = 0; i < 18; i++) begin
         if (vecs[i].clr) begin
            err_clr = 1'b1;
            @(posedge clk);
            #1 err_clr = 1'b0;
            @(negedge clk);
            check($sformatf("row%0d ovf after err_clr", i), 32'(ovf_sticky), 32'd0);
            check($sformatf("row%0d unf after err_clr", i), 32'(unf_sticky), 32'd0);
         end
         issue(vecs[i].op, vecs[i].data, 1'b0);
         check($sformatf("row%0d rsp_valid", i),  32'(rsp_valid),  32'd1);
         check($sformatf("row%0d cmd_ready", i),  32'(cmd_ready),  32'd0);
         check($sformatf("row%0d rsp_data", i),   32'(rsp_data),   32'(vecs[i].exp_data));
         check($sformatf("row%0d rsp_err", i),    32'(rsp_err),    32'(vecs[i].exp_err));
         check($sformatf("row%0d count", i),      32'(count),      32'(vecs[i].exp_cnt));
         check($sformatf("row%0d empty", i),      32'(empty),      32'(vecs[i].exp_cnt == 3'd0));
         check($sformatf("row%0d full", i),       32'(full),       32'(vecs[i].exp_cnt == 3'd4));
         check($sformatf("row%0d ovf_sticky", i), 32'(ovf_sticky), 32'(vecs[i].exp_ovf));
         check($sformatf("row%0d unf_sticky", i), 32'(unf_sticky), 32'(vecs[i].exp_unf));
      end

      // Fill, overflow, then overflow again with a coincident err_clr
      issue(OP_CLEAR, 8'h00, 1'b0);
      for (int k = 0; k < 4; k++) begin
         issue(OP_PUSH, 8'(8'h61 + k), 1'b0);
      end
      check("fill full", 32'(full), 32'd1);
      issue(OP_PUSH, 8'h99, 1'b0);
      check("ovf set", 32'(ovf_sticky), 32'd1);
      check("unf still set", 32'(unf_sticky), 32'd1);
      issue(OP_PUSH, 8'h9A, 1'b1);
      check("set-wins rsp_err", 32'(rsp_err), 32'd1);
      check("set-wins ovf", 32'(ovf_sticky), 32'd1);
      check("set-wins unf cleared", 32'(unf_sticky), 32'd0);
      check("set-wins count", 32'(count), 32'd4);

      // Back-pressure: hold rsp_ready low for 5 cycles after a POP
      @(negedge clk);
      rsp_ready = 1'b0;
      issue(OP_POP, 8'h00, 1'b0);
      cmd_valid = 1'b1;
      cmd_op    = OP_PUSH;
      cmd_data  = 8'h77;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
         check($sformatf("stall%0d rsp_data", c),  32'(rsp_data),  32'h64);
         check($sformatf("stall%0d rsp_err", c),   32'(rsp_err),   32'd0);
         check($sformatf("stall%0d cmd_ready", c), 32'(cmd_ready), 32'd0);
         check($sformatf("stall%0d count", c),     32'(count),     32'd3);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release rsp_valid", 32'(rsp_valid), 32'd0);
      check("release cmd_ready", 32'(cmd_ready), 32'd1);
      check("release count",     32'(count),     32'd3);
      issue(OP_POP, 8'h00, 1'b0);
      check("post-stall pop data",  32'(rsp_data), 32'h63);
      check("post-stall pop count", 32'(count),    32'd2);

      // Reset while a response is pending with count=3; a command in the reset cycle is ignored
      @(negedge clk);
      rsp_ready = 1'b0;
      issue(OP_PUSH, 8'h70, 1'b0);
      check("pre-abort count", 32'(count), 32'd3);
      check("pre-abort ovf",   32'(ovf_sticky), 32'd1);
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = OP_PUSH;
      cmd_data  = 8'h88;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      check("abort rsp_valid", 32'(rsp_valid),  32'd0);
      check("abort cmd_ready", 32'(cmd_ready),  32'd1);
      check("abort count",     32'(count),      32'd0);
      check("abort empty",     32'(empty),      32'd1);
      check("abort ovf",       32'(ovf_sticky), 32'd0);
      check("abort unf",       32'(unf_sticky), 32'd0);
      issue(OP_POP, 8'h00, 1'b0);
      check("after abort pop err",  32'(rsp_err),  32'd1);
      check("after abort pop data", 32'(rsp_data), 32'd0);
      check("after abort count",    32'(count),    32'd0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_lifo_stack

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1..32.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, power of two, legal range 2..256.
REQ-003 SHALL define CW = $clog2(DEPTH+1) as the width of the count port.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-007 SHALL have port cmd_op, input, 2 bits: 00 PUSH, 01 POP, 10 PEEK, 11 CLEAR.
REQ-008 SHALL have port cmd_data, input, WIDTH bits: the push operand.
REQ-009 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-010 SHALL have port rsp_valid, output, 1 bit: a response is pending.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-012 SHALL have port rsp_data, output, WIDTH bits: POP/PEEK result; 0 for PUSH, CLEAR and errored commands.
REQ-013 SHALL have port rsp_err, output, 1 bit: the responded command failed (overflow or underflow).
REQ-014 SHALL have ports empty, full (output, 1 bit each) and count (output, CW bits): occupancy.
REQ-015 SHALL have ports ovf_sticky, unf_sticky (output, 1 bit each) and err_clr (input, 1 bit): sticky error flags and their clear.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and RESP; cmd_ready = (state==IDLE) and rsp_valid = (state==RESP), both purely decoded from state.
REQ-017 SHALL accept a command on cmd_valid && cmd_ready; the FSM moves IDLE->RESP on that same edge; cmd_valid is ignored in RESP.
REQ-018 SHALL hold rsp_data and rsp_err stable while in RESP, and move RESP->IDLE on rsp_valid && rsp_ready.
REQ-019 SHALL give a back-to-back throughput of one command per 2 cycles when rsp_ready is tied high; rsp_valid is asserted in the cycle after acceptance.
REQ-020 SHALL, on PUSH when not full, write mem[sp] <= cmd_data and sp <= sp+1 at the accept edge, with rsp_err=0.
REQ-021 SHALL, on PUSH when full, leave memory and sp unchanged, set rsp_err=1 and set ovf_sticky=1.
REQ-022 SHALL, on POP when not empty, register rsp_data <= mem[sp-1] and sp <= sp-1 at the accept edge.
REQ-023 SHALL, on PEEK when not empty, register rsp_data <= mem[sp-1] and leave sp unchanged.
REQ-024 SHALL, on POP or PEEK when empty, leave sp unchanged, set rsp_data=0 and rsp_err=1, and set unf_sticky=1.
REQ-025 SHALL, on CLEAR, set sp <= 0 without clearing memory and with rsp_err=0; CLEAR is legal when empty.
REQ-026 SHALL compute count = sp, empty = (sp==0) and full = (sp==DEPTH) combinationally from registered sp, with sp being CW bits wide and never exceeding DEPTH or wrapping below 0.
REQ-027 SHALL clear both sticky flags on err_clr; if err_clr coincides with a new error event, the flag SHALL end the cycle set (set wins).
REQ-028 SHALL never read and write the same entry in one cycle, so memory may be single-port.

Reset
REQ-029 SHALL, when rst is high at a rising clk edge, set state=IDLE, sp=0, rsp_data=0, rsp_err=0, ovf_sticky=0 and unf_sticky=0; memory contents are not reset.
REQ-030 SHALL, after reset, output cmd_ready=1, rsp_valid=0, empty=1, full=0 and count=0.
REQ-031 SHALL treat rst asserted during RESP as an abort: the pending response is dropped and the stack is emptied.
REQ-032 SHALL ignore any command presented in a reset cycle.

Structure
REQ-033 SHALL place the opcode constants (OP_PUSH, OP_POP, OP_PEEK, OP_CLEAR) and the state encoding in shared package stack_pkg.
REQ-034 SHALL instantiate one sub-module, stack_mem: a parametrised WIDTH x DEPTH single-port register array with synchronous write and asynchronous read; the FSM and pointer logic stay in lifo_stack.

Verification (WIDTH=8, DEPTH=4)
REQ-035 SHALL verify: PUSH 0x11, 0x22, 0x33, then POP x3 with rsp_ready=1 -> rsp_data 0x33, 0x22, 0x11, rsp_err=0, with empty=1 at the end.
REQ-036 SHALL verify: PUSH x4 (full=1, count=4), then PUSH 0x55 -> rsp_err=1, ovf_sticky=1, count stays 4, and a following POP returns the 4th pushed value.
REQ-037 SHALL verify: POP when empty -> rsp_data=0x00, rsp_err=1, unf_sticky=1; err_clr pulse -> unf_sticky=0.
REQ-038 SHALL verify: PEEK after PUSH 0xA5 -> rsp_data=0xA5 with count still 1; then CLEAR -> count=0 and PEEK -> rsp_err=1.
REQ-039 SHALL verify: hold rsp_ready=0 for 5 cycles after a POP -> rsp_valid and rsp_data stable, cmd_ready=0 and new commands ignored; release -> IDLE the next cycle.
REQ-040 SHALL verify: assert rst while in RESP with count=3 -> next cycle rsp_valid=0, cmd_ready=1, count=0 and both sticky flags 0.
